// File: rtl/heat_sweep_scheduler.sv
// Cell/sweep sequencer for the 5-point heat stencil, with solver/host grid arbitration.
// Optional early exit on convergence when CONVERGE_DETECT_EN is defined.
module heat_sweep_scheduler #(
  parameter int unsigned GRID_W = 6,
  parameter int unsigned GRID_H = 6,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned ITER_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [ITER_W-1:0] iter_target,
  input  logic              host_req,
  input  logic [ADDR_W-1:0] host_addr,
  output logic              host_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ADDR_W-1:0] nb_l,
  output logic [ADDR_W-1:0] nb_r,
  output logic [ADDR_W-1:0] nb_u,
  output logic [ADDR_W-1:0] nb_d,
  output logic              at_edge,
  output logic              upd_we,
  input  logic              cell_changed,
  output logic              busy,
  output logic              done,
  output logic              converged,
  output logic [ITER_W-1:0] iter_count
);

  localparam int unsigned XW = (GRID_W > 1) ? $clog2(GRID_W) : 1;
  localparam int unsigned YW = (GRID_H > 1) ? $clog2(GRID_H) : 1;

  typedef enum logic [1:0] {StIdle, StSweep, StSwap, StDone} state_e;

  state_e            state_q, state_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [ITER_W-1:0] iter_q, iter_d, iter_inc;
  logic              gnt_q, gnt_d;
  logic              x_last, y_last;
  logic [ADDR_W-1:0] sol_addr;

  assign x_last   = (x_q == XW'(GRID_W - 1));
  assign y_last   = (y_q == YW'(GRID_H - 1));
  assign sol_addr = ADDR_W'(y_q) * ADDR_W'(GRID_W) + ADDR_W'(x_q);
  // Saturates so an unbounded run (target 0) never wraps the readout.
  assign iter_inc = (&iter_q) ? iter_q : iter_q + ITER_W'(1);

  assign busy       = (state_q == StSweep) || (state_q == StSwap);
  assign done       = (state_q == StDone);
  assign host_gnt   = gnt_q;
  assign upd_we     = (state_q == StSweep) && !gnt_q;
  assign iter_count = iter_q;
  assign at_edge    = (x_q == '0) || x_last || (y_q == '0) || y_last;
  assign mem_addr   = gnt_q ? host_addr : sol_addr;

  // Neighbours only meaningful while sweeping; zero otherwise to match the reset image.
  always_comb begin
    nb_l = '0;
    nb_r = '0;
    nb_u = '0;
    nb_d = '0;
    if (state_q == StSweep) begin
      nb_l = (x_q == '0) ? sol_addr : sol_addr - ADDR_W'(1);
      nb_r = x_last      ? sol_addr : sol_addr + ADDR_W'(1);
      nb_u = (y_q == '0) ? sol_addr : sol_addr - ADDR_W'(GRID_W);
      nb_d = y_last      ? sol_addr : sol_addr + ADDR_W'(GRID_W);
    end
  end

`ifdef CONVERGE_DETECT_EN
  logic flag_q, flag_d;
  logic conv_q, conv_d;
  assign converged = conv_q;
`else
  logic unused_cell_changed;
  assign unused_cell_changed = cell_changed;
  assign converged = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    iter_d  = iter_q;
    // While busy a grant must be followed by a solver step before the next grant.
    gnt_d   = host_req && !(busy && gnt_q);
`ifdef CONVERGE_DETECT_EN
    flag_d  = flag_q;
    conv_d  = conv_q;
`endif
    if (stop) begin
      state_d = StIdle;
      x_d     = '0;
      y_d     = '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_d = StSweep;
            x_d     = '0;
            y_d     = '0;
            iter_d  = '0;
`ifdef CONVERGE_DETECT_EN
            flag_d  = 1'b0;
            conv_d  = 1'b0;
`endif
          end
        end
        StSweep: begin
          if (!gnt_q) begin
`ifdef CONVERGE_DETECT_EN
            if (cell_changed && !at_edge) flag_d = 1'b1;
`endif
            if (x_last) begin
              x_d = '0;
              if (y_last) begin
                y_d     = '0;
                state_d = StSwap;
              end else begin
                y_d = y_q + YW'(1);
              end
            end else begin
              x_d = x_q + XW'(1);
            end
          end
        end
        StSwap: begin
          if (!gnt_q) begin
            iter_d  = iter_inc;
            state_d = StSweep;
            if ((iter_target != '0) && (iter_inc == iter_target)) state_d = StDone;
`ifdef CONVERGE_DETECT_EN
            if (!flag_q) begin
              state_d = StDone;
              conv_d  = 1'b1;
            end
            flag_d = 1'b0;
`endif
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      iter_q  <= '0;
      gnt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      iter_q  <= iter_d;
      gnt_q   <= gnt_d;
    end
  end

`ifdef CONVERGE_DETECT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_q <= 1'b0;
      conv_q <= 1'b0;
    end else begin
      flag_q <= flag_d;
      conv_q <= conv_d;
    end
  end
`endif

endmodule

// File: tb/tb_heat_sweep_scheduler.sv
// Directed bench for heat_sweep_scheduler on a 6x6 grid; expected values computed by hand.
module tb_heat_sweep_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [11:0] iter_target = '0;
  logic        host_req = 1'b0;
  logic [5:0]  host_addr = '0;
  logic        host_gnt;
  logic [5:0]  mem_addr, nb_l, nb_r, nb_u, nb_d;
  logic        at_edge, upd_we, cell_changed, busy, done, converged;
  logic [11:0] iter_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  heat_sweep_scheduler #(
    .GRID_W(6), .GRID_H(6), .ADDR_W(6), .ITER_W(12)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .stop         (stop),
    .iter_target  (iter_target),
    .host_req     (host_req),
    .host_addr    (host_addr),
    .host_gnt     (host_gnt),
    .mem_addr     (mem_addr),
    .nb_l         (nb_l),
    .nb_r         (nb_r),
    .nb_u         (nb_u),
    .nb_d         (nb_d),
    .at_edge      (at_edge),
    .upd_we       (upd_we),
    .cell_changed (cell_changed),
    .busy         (busy),
    .done         (done),
    .converged    (converged),
    .iter_count   (iter_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_we"}, 32'(upd_we), 0);
    chk({tag, "_gnt"}, 32'(host_gnt), 0);
    chk({tag, "_conv"}, 32'(converged), 0);
    chk({tag, "_iter"}, 32'(iter_count), 0);
    chk({tag, "_edge"}, 32'(at_edge), 1);
    chk({tag, "_addr"}, 32'(mem_addr), 0);
    chk({tag, "_nbs"}, {8'(nb_l), 8'(nb_r), 8'(nb_u), 8'(nb_d)}, 0);
  endtask

  initial begin
    int n;
    cell_changed = 1'b0;
    repeat (2) @(negedge clk);
    reset_vals("rst");
    rst_n = 1'b1;

    // Run 1: two sweeps; cycle 0 is the start cycle.
    @(negedge clk);
    iter_target = 12'd2;
    start = 1'b1;
    for (int c = 1; c <= 76; c++) begin
      @(negedge clk);
      chk($sformatf("r1_we_c%0d", c), 32'(upd_we), 32'((c <= 36) || (c >= 38 && c <= 73)));
      chk($sformatf("r1_done_c%0d", c), 32'(done), 32'(c >= 75));
      if (c == 1) begin
        start = 1'b0;
        chk("cell0_addr", 32'(mem_addr), 0);
        chk("cell0_nbs", {8'(nb_l), 8'(nb_r), 8'(nb_u), 8'(nb_d)}, {8'd0, 8'd1, 8'd0, 8'd6});
        chk("cell0_edge", 32'(at_edge), 1);
      end
      if (c == 8) begin
        chk("cell7_addr", 32'(mem_addr), 7);
        chk("cell7_nbs", {8'(nb_l), 8'(nb_r), 8'(nb_u), 8'(nb_d)}, {8'd6, 8'd8, 8'd1, 8'd13});
        chk("cell7_edge", 32'(at_edge), 0);
      end
      if (c == 37 || c == 74) chk($sformatf("swap_busy_c%0d", c), 32'(busy), 1);
    end
    chk("r1_iter", 32'(iter_count), 2);
    chk("r1_conv", 32'(converged), 0);

    // Run 2: host_req held throughout; grants alternate with solver cells.
    iter_target = 12'd1;
    host_addr = 6'd33;
    host_req = 1'b1;
    start = 1'b1;
    for (int c = 1; c <= 75; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (c <= 72) begin
        chk($sformatf("r2_gnt_c%0d", c), 32'(host_gnt), 32'(c % 2));
        chk($sformatf("r2_we_c%0d", c), 32'(upd_we), 32'(1 - (c % 2)));
      end
      if (c == 1) chk("r2_host_addr", 32'(mem_addr), 33);
      if (c == 72) chk("r2_last_cell", 32'(mem_addr), 35);
      if (c == 73) chk("r2_swap_gnt", {30'd0, busy, host_gnt}, 3);
      if (c == 74) chk("r2_swap_run", {29'd0, busy, host_gnt, upd_we}, 4);
      if (c == 75) begin
        chk("r2_done", 32'(done), 1);
        chk("r2_iter", 32'(iter_count), 1);
        host_req = 1'b0;
      end
    end

    // Run 3: unbounded run, start ignored while busy, stop at cell 20.
    iter_target = 12'd0;
    start = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (c == 10) start = 1'b1;
      if (c == 11) begin
        chk("busy_start_ignored", 32'(mem_addr), 10);
        start = 1'b0;
      end
      if (c == 21) begin
        chk("stop_cell20_addr", 32'(mem_addr), 20);
        chk("stop_cell20_we", 32'(upd_we), 1);
        stop = 1'b1;
      end
      if (c == 22) begin
        chk("stop_idle", {29'd0, busy, done, upd_we}, 0);
        chk("stop_iter_held", 32'(iter_count), 0);
        stop = 1'b0;
      end
    end

    // start and stop together: stop wins.
    start = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    chk("start_stop_busy", 32'(busy), 0);
    start = 1'b0;
    stop = 1'b0;

    // Asynchronous reset mid-sweep.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    reset_vals("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", {30'd0, busy, done}, 0);

    // Convergence behaviour with cell_changed held low.
    iter_target = 12'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("conv_done_reached", 32'(done), 1);
`ifdef CONVERGE_DETECT_EN
    chk("conv_cycles", 32'(n), 38);
    chk("conv_flag", 32'(converged), 1);
    chk("conv_iter", 32'(iter_count), 1);
`else
    chk("noconv_cycles", 32'(n), 112);
    chk("noconv_flag", 32'(converged), 0);
    chk("noconv_iter", 32'(iter_count), 3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
